// File: rtl/eth_pkg.sv
// Shared types for the 10G RX path: AXI-Stream widths, the stored RX word
// layout and the RX frame buffer write-side state encoding.
package eth_pkg;

  localparam int AXIS_DATA_W = 64;
  localparam int AXIS_KEEP_W = 8;
  localparam int RX_WORD_W   = AXIS_DATA_W + AXIS_KEEP_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DROP  = 2'd2
  } wr_state_t;

  // Layout of one buffer word, MSB first: {tlast, tkeep, tdata}
  typedef struct packed {
    logic                   tlast;
    logic [AXIS_KEEP_W-1:0] tkeep;
    logic [AXIS_DATA_W-1:0] tdata;
  } rx_word_t;

  function automatic rx_word_t pack_rx_word(input logic                   tlast,
                                            input logic [AXIS_KEEP_W-1:0] tkeep,
                                            input logic [AXIS_DATA_W-1:0] tdata);
    rx_word_t w;
    w.tlast = tlast;
    w.tkeep = tkeep;
    w.tdata = tdata;
    return w;
  endfunction

endpackage

// File: rtl/eth_sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered read.
// The read register is cleared by reset so it can act as a downstream output stage.
module eth_sdp_ram #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 73
) (
  input  logic                  clk156,
  input  logic                  eth_rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [0:(1 << ADDR_WIDTH)-1];

  always_ff @(posedge clk156) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk156) begin
    if (!eth_rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/eth_rx_frame_fifo.sv
// Store-and-forward RX frame buffer: only frames that complete cleanly become
// visible to the reader; bad or overflowing frames are erased by rolling wr_ptr back.
module eth_rx_frame_fifo import eth_pkg::*; #(
  parameter int ADDR_WIDTH = 9,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                   clk156,
  input  logic                   eth_rst_n,
  input  logic                   s_axis_rx_tvalid,
  input  logic [AXIS_DATA_W-1:0] s_axis_rx_tdata,
  input  logic [AXIS_KEEP_W-1:0] s_axis_rx_tkeep,
  input  logic                   s_axis_rx_tlast,
  input  logic                   s_axis_rx_tuser,
  output logic                   m_axis_rx_tvalid,
  input  logic                   m_axis_rx_tready,
  output logic [AXIS_DATA_W-1:0] m_axis_rx_tdata,
  output logic [AXIS_KEEP_W-1:0] m_axis_rx_tkeep,
  output logic                   m_axis_rx_tlast,
  output logic                   m_axis_rx_tuser,
  output logic [CNT_WIDTH-1:0]   good_frames,
  output logic [CNT_WIDTH-1:0]   bad_frames,
  output logic [CNT_WIDTH-1:0]   ovf_frames
);

  localparam logic [ADDR_WIDTH:0] DEPTH   = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] PTR_ONE = (ADDR_WIDTH+1)'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  wr_state_t           state, state_nxt;
  logic [ADDR_WIDTH:0] wr_ptr, wr_commit, rd_ptr;
  logic [ADDR_WIDTH:0] wr_ptr_nxt, wr_commit_nxt;
  logic                full, empty;
  logic                we, rd_en;
  logic                inc_good, inc_bad, inc_ovf;
  rx_word_t            wr_word;
  rx_word_t            rd_word_p1;
  logic                vld_p1;

  // Occupancy is judged against the uncommitted write pointer so a frame in
  // progress can never overrun data the reader has not consumed yet.
  assign full    = (wr_ptr - rd_ptr) == DEPTH;
  assign empty   = (rd_ptr == wr_commit);
  assign wr_word = pack_rx_word(s_axis_rx_tlast, s_axis_rx_tkeep, s_axis_rx_tdata);

  always_ff @(posedge clk156) begin
    if (!eth_rst_n) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      wr_commit <= '0;
    end else begin
      state     <= state_nxt;
      wr_ptr    <= wr_ptr_nxt;
      wr_commit <= wr_commit_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    wr_ptr_nxt    = wr_ptr;
    wr_commit_nxt = wr_commit;
    we            = 1'b0;
    inc_good      = 1'b0;
    inc_bad       = 1'b0;
    inc_ovf       = 1'b0;
    case (state)
      IDLE, WRITE: begin
        if (s_axis_rx_tvalid) begin
          if (!full) begin
            we         = 1'b1;
            wr_ptr_nxt = wr_ptr + PTR_ONE;
            if (s_axis_rx_tlast) begin
              state_nxt = IDLE;
              if (!s_axis_rx_tuser) begin
                wr_commit_nxt = wr_ptr + PTR_ONE;
                inc_good      = 1'b1;
              end else begin
                wr_ptr_nxt = wr_commit;
                inc_bad    = 1'b1;
              end
            end else begin
              state_nxt = WRITE;
            end
          end else begin
            wr_ptr_nxt = wr_commit;
            if (s_axis_rx_tlast) begin
              inc_ovf   = 1'b1;
              state_nxt = IDLE;
            end else begin
              state_nxt = DROP;
            end
          end
        end
      end
      DROP: begin
        if (s_axis_rx_tvalid && s_axis_rx_tlast) begin
          inc_ovf   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---- read stage p1: RAM read register is the AXIS output register ----
  assign rd_en = !empty && (!vld_p1 || m_axis_rx_tready);

  eth_sdp_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (RX_WORD_W)
  ) u_ram (
    .clk156    (clk156),
    .eth_rst_n (eth_rst_n),
    .we        (we),
    .waddr     (wr_ptr[ADDR_WIDTH-1:0]),
    .wdata     (wr_word),
    .re        (rd_en),
    .raddr     (rd_ptr[ADDR_WIDTH-1:0]),
    .rdata     (rd_word_p1)
  );

  always_ff @(posedge clk156) begin
    if (!eth_rst_n) begin
      rd_ptr <= '0;
      vld_p1 <= 1'b0;
    end else if (rd_en) begin
      rd_ptr <= rd_ptr + PTR_ONE;
      vld_p1 <= 1'b1;
    end else if (m_axis_rx_tready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign m_axis_rx_tvalid = vld_p1;
  assign m_axis_rx_tdata  = rd_word_p1.tdata;
  assign m_axis_rx_tkeep  = rd_word_p1.tkeep;
  assign m_axis_rx_tlast  = rd_word_p1.tlast;
  assign m_axis_rx_tuser  = 1'b0;

  always_ff @(posedge clk156) begin
    if (!eth_rst_n) begin
      good_frames <= '0;
      bad_frames  <= '0;
      ovf_frames  <= '0;
    end else begin
      if (inc_good) good_frames <= good_frames + CNT_ONE;
      if (inc_bad)  bad_frames  <= bad_frames + CNT_ONE;
      if (inc_ovf)  ovf_frames  <= ovf_frames + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_eth_rx_frame_fifo.sv
// Scoreboard bench for eth_rx_frame_fifo: stimulus pushes expected beats of good
// frames, a negedge monitor pops and compares every accepted output beat.
module tb_eth_rx_frame_fifo;

  logic        clk156 = 1'b0;
  logic        rst_n;
  logic        s_tvalid, s_tlast, s_tuser;
  logic [63:0] s_tdata;
  logic [7:0]  s_tkeep;
  logic        m_tvalid, m_tready, m_tlast, m_tuser;
  logic [63:0] m_tdata;
  logic [7:0]  m_tkeep;
  logic [31:0] good_frames, bad_frames, ovf_frames;

  int          checks = 0;
  int          errors = 0;
  int          rdy_mode = 0;
  logic [72:0] exp_q[$];

  always #5 clk156 = ~clk156;

  eth_rx_frame_fifo #(.ADDR_WIDTH(9), .CNT_WIDTH(32)) dut (
    .clk156           (clk156),
    .eth_rst_n        (rst_n),
    .s_axis_rx_tvalid (s_tvalid),
    .s_axis_rx_tdata  (s_tdata),
    .s_axis_rx_tkeep  (s_tkeep),
    .s_axis_rx_tlast  (s_tlast),
    .s_axis_rx_tuser  (s_tuser),
    .m_axis_rx_tvalid (m_tvalid),
    .m_axis_rx_tready (m_tready),
    .m_axis_rx_tdata  (m_tdata),
    .m_axis_rx_tkeep  (m_tkeep),
    .m_axis_rx_tlast  (m_tlast),
    .m_axis_rx_tuser  (m_tuser),
    .good_frames      (good_frames),
    .bad_frames       (bad_frames),
    .ovf_frames       (ovf_frames)
  );

  // tready: 0 = always ready, 1 = never ready, otherwise random 50%
  initial begin : ready_gen
    m_tready = 1'b1;
    forever begin
      @(posedge clk156);
      #1;
      case (rdy_mode)
        0:       m_tready = 1'b1;
        1:       m_tready = 1'b0;
        default: m_tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin : monitor
    logic [72:0] held, act, exp;
    logic        have_hold;
    have_hold = 1'b0;
    forever begin
      @(negedge clk156);
      if (rst_n && m_tvalid) begin
        act = {m_tlast, m_tkeep, m_tdata};
        if (have_hold) begin
          checks++;
          if (act !== held) begin
            errors++;
            $display("FAIL hold_stable: got %h, required %h", act, held);
          end
        end
        if (m_tready) begin
          have_hold = 1'b0;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_beat: got %h, required no beat", act);
          end else begin
            exp = exp_q.pop_front();
            if (act !== exp || m_tuser !== 1'b0) begin
              errors++;
              $display("FAIL beat_data: got %h tuser %b, required %h tuser 0", act, m_tuser, exp);
            end
          end
        end else begin
          have_hold = 1'b1;
          held      = act;
        end
      end else begin
        have_hold = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic drive_beat(input logic [63:0] d, input logic [7:0] k, input logic l, input logic u);
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tkeep  = k;
    s_tlast  = l;
    s_tuser  = u;
    @(posedge clk156);
    #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tuser  = 1'b0;
  endtask

  task automatic send_frame(input int tid, input int fid, input int nb, input logic bad,
                            input logic keep_it, input logic [7:0] lkeep);
    for (int b = 0; b < nb; b++) begin
      logic [63:0] d;
      logic [7:0]  k;
      logic        l;
      d = {8'(tid), 24'(fid), 32'(b)};
      l = (b == nb - 1);
      k = l ? lkeep : 8'hFF;
      if (keep_it) exp_q.push_back({l, k, d});
      drive_beat(d, k, l, l & bad);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk156);
    #1;
    exp_q.delete();
    rst_n = 1'b1;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_tvalid) && n < budget) begin
      @(posedge clk156);
      #1;
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL drain_%s: %0d beats pending, required 0", name, exp_q.size());
    end
  endtask

  initial begin : stimulus
    rst_n    = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tkeep  = '0;
    s_tlast  = 1'b0;
    s_tuser  = 1'b0;
    repeat (3) @(posedge clk156);
    #1;
    chk("rst_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_tdata", m_tdata, 64'd0);
    chk("rst_tkeep", 64'(m_tkeep), 64'd0);
    chk("rst_tlast", 64'(m_tlast), 64'd0);
    chk("rst_tuser", 64'(m_tuser), 64'd0);
    chk("rst_good", 64'(good_frames), 64'd0);
    chk("rst_bad", 64'(bad_frames), 64'd0);
    chk("rst_ovf", 64'(ovf_frames), 64'd0);
    rst_n = 1'b1;

    // 1: single 8-beat good frame, check first-beat latency
    send_frame(1, 0, 8, 1'b0, 1'b1, 8'h0F);
    chk("t1_tvalid_at_commit", 64'(m_tvalid), 64'd0);
    @(posedge clk156);
    #1;
    chk("t1_tvalid_next", 64'(m_tvalid), 64'd1);
    wait_drain("t1", 100);
    chk("t1_good", 64'(good_frames), 64'd1);

    // 2: bad frame sandwiched between good frames
    do_reset();
    send_frame(2, 0, 4, 1'b0, 1'b1, 8'h07);
    send_frame(2, 1, 4, 1'b1, 1'b0, 8'hFF);
    send_frame(2, 2, 4, 1'b0, 1'b1, 8'h3F);
    wait_drain("t2", 100);
    chk("t2_good", 64'(good_frames), 64'd2);
    chk("t2_bad", 64'(bad_frames), 64'd1);
    chk("t2_ovf", 64'(ovf_frames), 64'd0);

    // 3: fill with tready low, 129th frame overflows, then drain in order
    rdy_mode = 1;
    do_reset();
    for (int f = 0; f < 129; f++)
      send_frame(3, f, 4, 1'b0, (f < 128), 8'hFF >> (f % 8));
    chk("t3_good", 64'(good_frames), 64'd128);
    chk("t3_ovf", 64'(ovf_frames), 64'd1);
    chk("t3_tvalid_held", 64'(m_tvalid), 64'd1);
    rdy_mode = 0;
    wait_drain("t3", 2000);

    // 4: random tready, alternating 1/9-beat frames, 600 beats wrap the buffer
    rdy_mode = 2;
    do_reset();
    for (int f = 0; f < 120; f++)
      send_frame(4, f, (f % 2 == 1) ? 9 : 1, 1'b0, 1'b1, 8'hFF >> (f % 8));
    wait_drain("t4", 3000);
    chk("t4_good", 64'(good_frames), 64'd120);
    chk("t4_ovf", 64'(ovf_frames), 64'd0);
    rdy_mode = 0;

    // 5: reset mid-frame with two frames buffered
    rdy_mode = 1;
    do_reset();
    send_frame(5, 0, 4, 1'b0, 1'b1, 8'hFF);
    send_frame(5, 1, 4, 1'b0, 1'b1, 8'hFF);
    drive_beat(64'h0500_0002_0000_0000, 8'hFF, 1'b0, 1'b0);
    drive_beat(64'h0500_0002_0000_0001, 8'hFF, 1'b0, 1'b0);
    chk("t5_good_pre", 64'(good_frames), 64'd2);
    do_reset();
    chk("t5_tvalid", 64'(m_tvalid), 64'd0);
    chk("t5_good_rst", 64'(good_frames), 64'd0);
    chk("t5_ovf_rst", 64'(ovf_frames), 64'd0);
    rdy_mode = 0;
    send_frame(5, 3, 3, 1'b0, 1'b1, 8'h3F);
    wait_drain("t5", 100);
    chk("t5_good", 64'(good_frames), 64'd1);

    // 6: 600-beat frame exceeds depth and is dropped, next frame passes
    do_reset();
    send_frame(6, 0, 600, 1'b0, 1'b0, 8'hFF);
    send_frame(6, 1, 2, 1'b0, 1'b1, 8'h03);
    wait_drain("t6", 200);
    chk("t6_ovf", 64'(ovf_frames), 64'd1);
    chk("t6_good", 64'(good_frames), 64'd1);
    chk("t6_bad", 64'(bad_frames), 64'd0);

    repeat (3) @(posedge clk156);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
